// File: rtl/aoi_5_sweep_checker.sv
// Exhaustive response checker for the 8-input AOI_5 gate: sweeps all 256 vectors and compares y_i to a golden model.
// Optional: define AOI_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch, leaving that vector on vec_o.
module aoi_5_sweep_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] vec_o,
  input  logic       y_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] settleCnt_q, settleCnt_d;
  logic [7:0] vec_q, vec_d;
  logic [8:0] errCount_q, errCount_d;
  logic [7:0] firstFailVec_q, firstFailVec_d;
  logic       firstFailValid_q, firstFailValid_d;

  logic expectedY;
  logic mismatch;
  logic stopOnFail;

  assign expectedY = ~((vec_q[7] & vec_q[6]) | (vec_q[5] & vec_q[4]) |
                       (vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]));
  assign mismatch  = (y_i != expectedY);

`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
  assign stopOnFail = mismatch;
`else
  assign stopOnFail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      settleCnt_q      <= 4'd0;
      vec_q            <= 8'h00;
      errCount_q       <= 9'd0;
      firstFailVec_q   <= 8'h00;
      firstFailValid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      settleCnt_q      <= settleCnt_d;
      vec_q            <= vec_d;
      errCount_q       <= errCount_d;
      firstFailVec_q   <= firstFailVec_d;
      firstFailValid_q <= firstFailValid_d;
    end
  end

  // Each vector spends SETTLE_CYCLES cycles in SETTLE plus one in SAMPLE before advancing.
  always_comb begin
    state_d          = state_q;
    settleCnt_d      = settleCnt_q;
    vec_d            = vec_q;
    errCount_d       = errCount_q;
    firstFailVec_d   = firstFailVec_q;
    firstFailValid_d = firstFailValid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d            = 8'h00;
          errCount_d       = 9'd0;
          firstFailVec_d   = 8'h00;
          firstFailValid_d = 1'b0;
          settleCnt_d      = SETTLE_RELOAD;
          state_d          = SETTLE;
        end
      end
      SETTLE: begin
        if (settleCnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          settleCnt_d = settleCnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          errCount_d = errCount_q + 9'd1;
          if (!firstFailValid_q) begin
            firstFailVec_d   = vec_q;
            firstFailValid_d = 1'b1;
          end
        end
        if (stopOnFail || (vec_q == 8'hFF)) begin
          state_d = DONE;
        end else begin
          vec_d       = vec_q + 8'd1;
          settleCnt_d = SETTLE_RELOAD;
          state_d     = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign vec_o            = vec_q;
  assign busy             = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done             = (state_q == DONE);
  assign pass             = done && (errCount_q == 9'd0);
  assign err_count        = errCount_q;
  assign first_fail_vec   = firstFailVec_q;
  assign first_fail_valid = firstFailValid_q;

endmodule
